div_rep_sub: RTL

//   Unsigned integer divider by repeated subtraction; the inverse of the repeated-addition multiplier.

---
 rtl/div_rep_pkg.sv | 15 +
 rtl/div_rep_ctrl.sv | 85 ++++++++
 rtl/div_rep_sub.sv | 104 ++++++++++
 3 files changed

// File: rtl/div_rep_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_rep_pkg;

  localparam int unsigned DIV_REP_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_CHK  = 3'd3,
    S_SUB  = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/div_rep_ctrl.sv
// Control FSM for div_rep_sub: sequences operand loads, the subtract loop
// and the sticky done state; strobes drive the datapath in div_rep_sub.
module div_rep_ctrl
  import div_rep_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic a_ge_b,
  input  logic b_eqz,
  output logic ld_a,
  output logic ld_b,
  output logic clr_q,
  output logic dec_a,
  output logic set_dbz,
  output logic clr_dbz,
  output logic done,
  output logic busy
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    clr_q   = 1'b0;
    dec_a   = 1'b0;
    set_dbz = 1'b0;
    clr_dbz = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LDA;
      S_LDA: begin
        ld_a    = 1'b1;
        state_d = S_LDB;
      end
      S_LDB: begin
        ld_b    = 1'b1;
        clr_q   = 1'b1;
        state_d = S_CHK;
      end
      S_CHK: begin
        if (b_eqz) begin
          set_dbz = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (a_ge_b) dec_a = 1'b1;
        else        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          clr_dbz = 1'b1;
          state_d = S_LDA;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered from the next state so they line up with state_q.
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_LDA) || (state_d == S_LDB) ||
             (state_d == S_CHK) || (state_d == S_SUB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/div_rep_sub.sv
// Unsigned divider by repeated subtraction; operands arrive on data_in over two cycles.
// Optional subtraction counter port iter_cnt enabled by DIVREP_ITER_CNT_EN.
module div_rep_sub
  import div_rep_pkg::*;
#(
  parameter int unsigned W = DIV_REP_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         div_by_zero,
  output logic         busy
`ifdef DIVREP_ITER_CNT_EN
  ,
  output logic [W-1:0] iter_cnt
`endif
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] q_q, q_d;
  logic         dbz_q, dbz_d;
  logic         a_ge_b, b_eqz;
  logic         ld_a, ld_b, clr_q, dec_a, set_dbz, clr_dbz;

  div_rep_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a_ge_b  (a_ge_b),
    .b_eqz   (b_eqz),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .clr_q   (clr_q),
    .dec_a   (dec_a),
    .set_dbz (set_dbz),
    .clr_dbz (clr_dbz),
    .done    (done),
    .busy    (busy)
  );

  assign a_ge_b = (a_q >= b_q);
  assign b_eqz  = (b_q == '0);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    q_d   = q_q;
    dbz_d = dbz_q;
    if (ld_a) a_d = data_in;
    if (ld_b) b_d = data_in;
    if (clr_q) q_d = '0;
    if (set_dbz) begin
      dbz_d = 1'b1;
      q_d   = '1;
    end
    // The a_ge_b guard on dec_a keeps the subtract borrow-free and Q below 2^W.
    if (dec_a) begin
      a_d = a_q - b_q;
      q_d = q_q + W'(1);
    end
    if (clr_dbz) dbz_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      q_q   <= q_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = a_q;
  assign div_by_zero = dbz_q;

`ifdef DIVREP_ITER_CNT_EN
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_b)  cnt_d = '0;
    if (dec_a) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign iter_cnt = cnt_q;
`endif

endmodule
